// File: rtl/au_cnt_gray.sv
// -----------------------------------------------------------------------------
// au_cnt_gray
// Registered Gray-code up/down counter with a lockstep binary image.
// Used for clock-domain-crossing FIFO pointers where downstream comparators
// need both the Gray and the binary form of the same count.
//
// Parameters:
//   WIDTH : count word length in bits (2..32)
//   ARCH  : 0 = Gray->binary, +/-1, binary->Gray
//           1 = direct Gray step by the parity / lowest-set-bit rule
//           Both architectures produce identical outputs.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   clr    in   synchronous clear to zero
//   load   in   synchronous parallel load of d
//   d      in   Gray-coded load value (WIDTH)
//   en     in   count enable, one step per enabled cycle
//   dn     in   direction, 0 = up, 1 = down (sampled only when en=1)
//   z      out  Gray-coded count, registered (WIDTH)
//   z_bin  out  binary equivalent of z, registered (WIDTH)
//   tc     out  terminal-count flag, registered one-cycle pulse
//
// Build option:
//   AU_CNT_GRAY_SAT_EN : when defined the counter saturates at the ends of
//   its range instead of wrapping; tc then pulses on each blocked step.
//   Priority per edge: rst_n, clr, load, en.
// -----------------------------------------------------------------------------
module au_cnt_gray #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             dn,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] z_bin,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  // Gray code of the all-ones binary value: MSB only.
  localparam logic [WIDTH-1:0] MAXG = {1'b1, {(WIDTH-1){1'b0}}};

  // Prefix XOR from the MSB down converts Gray to binary.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Parity of a Gray word equals the LSB of its binary value.
  function automatic logic gray_parity(input logic [WIDTH-1:0] g);
    return ^g;
  endfunction

  logic [WIDTH-1:0] r_z;
  logic [WIDTH-1:0] r_bin;
  logic             r_tc;

  logic [WIDTH-1:0] w_nxt_gray;
  logic [WIDTH-1:0] w_nxt_bin;
  logic             w_at_bound;

  generate
    if (ARCH == 0) begin : g_arith
      logic [WIDTH-1:0] w_cur_bin;

      // Convert, add or subtract one in binary, convert back.
      always_comb begin
        w_cur_bin  = gray2bin(r_z);
        if (dn) begin
          w_nxt_bin = w_cur_bin - ONE;
        end else begin
          w_nxt_bin = w_cur_bin + ONE;
        end
        w_nxt_gray = bin2gray(w_nxt_bin);
      end
    end else begin : g_direct
      logic [WIDTH-1:0] w_low;
      logic             w_par;

      // Up: even parity flips bit 0, odd parity flips the bit left of the
      // lowest set bit. Down is the mirror. When that bit would fall off the
      // top (MAXG going up, zero going down) the MSB flips, which is the wrap.
      always_comb begin
        w_par = gray_parity(r_z);
        w_low = r_z & (~r_z + ONE);
        if (w_par == dn) begin
          w_nxt_gray = r_z ^ ONE;
        end else if (!dn && (r_z == MAXG)) begin
          w_nxt_gray = ZERO;
        end else if (dn && (r_z == ZERO)) begin
          w_nxt_gray = MAXG;
        end else begin
          w_nxt_gray = r_z ^ (w_low << 1);
        end
        w_nxt_bin = gray2bin(w_nxt_gray);
      end
    end
  endgenerate

  // A step from the range end in the current direction wraps (or is blocked).
  always_comb begin
    if (dn) begin
      w_at_bound = (r_z == ZERO);
    end else begin
      w_at_bound = (r_z == MAXG);
    end
  end

  // Count register, binary image and terminal-count flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_z   <= ZERO;
      r_bin <= ZERO;
      r_tc  <= 1'b0;
    end else if (clr) begin
      r_z   <= ZERO;
      r_bin <= ZERO;
      r_tc  <= 1'b0;
    end else if (load) begin
      r_z   <= d;
      r_bin <= gray2bin(d);
      r_tc  <= 1'b0;
    end else if (en) begin
      if (w_at_bound) begin
`ifdef AU_CNT_GRAY_SAT_EN
        r_z   <= r_z;
        r_bin <= r_bin;
`else
        r_z   <= w_nxt_gray;
        r_bin <= w_nxt_bin;
`endif
        r_tc  <= 1'b1;
      end else begin
        r_z   <= w_nxt_gray;
        r_bin <= w_nxt_bin;
        r_tc  <= 1'b0;
      end
    end else begin
      r_z   <= r_z;
      r_bin <= r_bin;
      r_tc  <= 1'b0;
    end
  end

  assign z     = r_z;
  assign z_bin = r_bin;
  assign tc    = r_tc;

endmodule
